// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register carrying PC + instruction between two CPU
// stages. A two-entry MAIN/SKID buffer gives full throughput while keeping
// o_up_ready a pure register output (no combinational path from i_dn_ready).
// Supports synchronous flush, hazard stall, bubble masking and saturating
// stall/flush event counters.
module pipe_stage_skid #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [PC_W-1:0]   i_up_pc,
  input  logic [INST_W-1:0] i_up_inst,
  output logic              o_dn_valid,
  input  logic              i_dn_ready,
  output logic [PC_W-1:0]   o_dn_pc,
  output logic [INST_W-1:0] o_dn_inst,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Saturating +1: holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_main_pc;
  logic [INST_W-1:0]   r_main_inst;
  logic [PC_W-1:0]     r_skid_pc;
  logic [INST_W-1:0]   r_skid_inst;
  logic [PC_W-1:0]     w_main_pc_nxt;
  logic [INST_W-1:0]   w_main_inst_nxt;
  logic [PC_W-1:0]     w_skid_pc_nxt;
  logic [INST_W-1:0]   w_skid_inst_nxt;
  logic                r_up_ready;
  logic                r_dn_valid;
  logic [1:0]          r_occupancy;
  logic [1:0]          w_occupancy_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_up_fire;
  logic                w_dn_fire;

  assign w_up_fire = i_up_valid & r_up_ready;
  assign w_dn_fire = r_dn_valid & i_dn_ready & ~i_stall;

  // Next-state and payload steering; MAIN is cleared whenever the stage
  // empties so the outputs show a clean bubble rather than stale data.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_pc_nxt   = r_main_pc;
    w_main_inst_nxt = r_main_inst;
    w_skid_pc_nxt   = r_skid_pc;
    w_skid_inst_nxt = r_skid_inst;
    case (r_state)
      ST_EMPTY: begin
        if (w_up_fire) begin
          w_state_nxt     = ST_ONE;
          w_main_pc_nxt   = i_up_pc;
          w_main_inst_nxt = i_up_inst;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_up_fire && w_dn_fire) begin
          w_main_pc_nxt   = i_up_pc;
          w_main_inst_nxt = i_up_inst;
        end else if (w_up_fire) begin
          w_state_nxt     = ST_FULL;
          w_skid_pc_nxt   = i_up_pc;
          w_skid_inst_nxt = i_up_inst;
        end else if (w_dn_fire) begin
          w_state_nxt     = ST_EMPTY;
          w_main_pc_nxt   = {PC_W{1'b0}};
          w_main_inst_nxt = NOP_INST;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
        if (w_dn_fire) begin
          w_state_nxt     = ST_ONE;
          w_main_pc_nxt   = r_skid_pc;
          w_main_inst_nxt = r_skid_inst;
          w_skid_pc_nxt   = {PC_W{1'b0}};
          w_skid_inst_nxt = NOP_INST;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt     = ST_EMPTY;
        w_main_pc_nxt   = {PC_W{1'b0}};
        w_main_inst_nxt = NOP_INST;
        w_skid_pc_nxt   = {PC_W{1'b0}};
        w_skid_inst_nxt = NOP_INST;
      end
    endcase
    // Flush overrides everything: held entries and any incoming entry vanish.
    if (i_flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_pc_nxt   = {PC_W{1'b0}};
      w_main_inst_nxt = NOP_INST;
      w_skid_pc_nxt   = {PC_W{1'b0}};
      w_skid_inst_nxt = NOP_INST;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Occupancy encoding of the upcoming state, registered alongside it.
  always_comb begin
    w_occupancy_nxt = 2'd0;
    case (w_state_nxt)
      ST_EMPTY: w_occupancy_nxt = 2'd0;
      ST_ONE:   w_occupancy_nxt = 2'd1;
      ST_FULL:  w_occupancy_nxt = 2'd2;
      default:  w_occupancy_nxt = 2'd0;
    endcase
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_pc   <= {PC_W{1'b0}};
      r_main_inst <= NOP_INST;
      r_skid_pc   <= {PC_W{1'b0}};
      r_skid_inst <= NOP_INST;
      r_up_ready  <= 1'b1;
      r_dn_valid  <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_pc   <= w_main_pc_nxt;
      r_main_inst <= w_main_inst_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_skid_inst <= w_skid_inst_nxt;
      r_up_ready  <= (w_state_nxt != ST_FULL);
      r_dn_valid  <= (w_state_nxt != ST_EMPTY);
      r_occupancy <= w_occupancy_nxt;
    end
  end

  // Saturating event counters; only reset clears them, flush does not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_dn_valid && !w_dn_fire) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (i_flush) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign o_up_ready  = r_up_ready;
  assign o_dn_valid  = r_dn_valid;
  assign o_dn_pc     = r_main_pc;
  assign o_dn_inst   = r_main_inst;
  assign o_occupancy = r_occupancy;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the driver pushes every accepted
// entry into a queue; an independent monitor pops and compares each entry
// the DUT hands downstream, and checks occupancy and bubble masking.
module tb_pipe_stage_skid;

  localparam int          PC_W   = 32;
  localparam int          INST_W = 32;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_flush = 1'b0;
  logic              i_stall = 1'b0;
  logic              i_up_valid = 1'b0;
  logic              o_up_ready;
  logic [PC_W-1:0]   i_up_pc = '0;
  logic [INST_W-1:0] i_up_inst = '0;
  logic              o_dn_valid;
  logic              i_dn_ready = 1'b0;
  logic [PC_W-1:0]   o_dn_pc;
  logic [INST_W-1:0] o_dn_inst;
  logic [1:0]        o_occupancy;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  pipe_stage_skid #(
    .PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_stall(i_stall),
    .i_up_valid(i_up_valid), .o_up_ready(o_up_ready),
    .i_up_pc(i_up_pc), .i_up_inst(i_up_inst),
    .o_dn_valid(o_dn_valid), .i_dn_ready(i_dn_ready),
    .o_dn_pc(o_dn_pc), .o_dn_inst(o_dn_inst), .o_occupancy(o_occupancy),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic stl, input logic fl);
    i_up_valid = v; i_up_pc = pc; i_up_inst = inst;
    i_dn_ready = rdy; i_stall = stl; i_flush = fl;
    @(negedge clk); #1;
    if (rst_n && v && o_up_ready && !fl) sb_q.push_back({pc, inst});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_up_valid = 1'b0; i_flush = 1'b0; i_stall = 1'b0; i_dn_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops on every downstream handshake, drops the model on flush/reset.
  always @(negedge clk) begin
    logic [63:0] exp_e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      check("occupancy", {62'd0, o_occupancy}, sb_q.size());
      if (!o_dn_valid) begin
        check("bubble_inst", {32'd0, o_dn_inst}, {32'd0, NOP});
        check("bubble_pc", {32'd0, o_dn_pc}, 64'd0);
      end
      if (o_dn_valid && i_dn_ready && !i_stall) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", {o_dn_pc, o_dn_inst}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          exp_e = sb_q.pop_front();
          check("dn_data", {o_dn_pc, o_dn_inst}, exp_e);
        end
      end
      if (i_flush) sb_q.delete();
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1 reset state, then asynchronous reset in mid-cycle while holding data
    check("rst_valid", {63'd0, o_dn_valid}, 64'd0);
    check("rst_ready", {63'd0, o_up_ready}, 64'd1);
    check("rst_inst", {32'd0, o_dn_inst}, {32'd0, NOP});
    drive(1'b1, 32'h100, 32'h1111_0001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h104, 32'h1111_0002, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h108, 32'h1111_0003, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", {63'd0, o_dn_valid}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, o_dn_valid}, 64'd0);
    check("arst_inst", {32'd0, o_dn_inst}, {32'd0, NOP});
    check("arst_pc", {32'd0, o_dn_pc}, 64'd0);
    check("arst_ready", {63'd0, o_up_ready}, 64'd1);
    check("arst_stall_cnt", {60'd0, o_stall_cnt}, 64'd0);
    check("arst_flush_cnt", {60'd0, o_flush_cnt}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2 streaming: 8 back-to-back entries, 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      check("stream_occ_le1", {63'd0, (o_occupancy <= 2'd1)}, 64'd1);
      check("stream_pc", {32'd0, o_dn_pc}, {32'd0, 32'(i * 4)});
    end
    idle(3);

    // 3 backpressure: stall 3 cycles with upstream valid
    do_reset();
    drive(1'b1, 32'h200, 32'hB000_0000, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 32'hB000_0001, 1'b1, 1'b1, 1'b0);
    check("bp_occ_full", {62'd0, o_occupancy}, 64'd2);
    check("bp_ready_low", {63'd0, o_up_ready}, 64'd0);
    drive(1'b1, 32'h208, 32'hB000_0002, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'h20C, 32'hB000_0003, 1'b1, 1'b1, 1'b0);
    check("bp_stall_cnt", {60'd0, o_stall_cnt}, 64'd3);
    check("bp_head_pc", {32'd0, o_dn_pc}, 64'h200);
    idle(3);
    check("bp_stall_cnt_hold", {60'd0, o_stall_cnt}, 64'd3);

    // 4 flush while FULL with an incoming entry
    do_reset();
    drive(1'b1, 32'h300, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
    check("fl_full", {62'd0, o_occupancy}, 64'd2);
    drive(1'b1, 32'h308, 32'hC000_0002, 1'b0, 1'b0, 1'b1);
    check("fl_valid", {63'd0, o_dn_valid}, 64'd0);
    check("fl_inst", {32'd0, o_dn_inst}, {32'd0, NOP});
    check("fl_ready", {63'd0, o_up_ready}, 64'd1);
    check("fl_cnt", {60'd0, o_flush_cnt}, 64'd1);
    idle(3);

    // 5 stall counter saturation at 2^CNT_W-1
    do_reset();
    drive(1'b1, 32'h400, 32'hD000_0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (i == 13) check("sat_14", {60'd0, o_stall_cnt}, 64'd14);
    end
    check("sat_15", {60'd0, o_stall_cnt}, 64'd15);
    idle(2);

    // 6 random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(99, 0) < 70), 32'(i * 4), $urandom,
            1'($urandom_range(99, 0) < 70), 1'($urandom_range(99, 0) < 20),
            1'($urandom_range(99, 0) < 3));
    end
    idle(4);
    check("rand_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
    check("rand_occ_zero", {62'd0, o_occupancy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
